// File: rtl/pc_out_arbiter.sv
// pc_out_arbiter: merges Nin input streams into one registered output channel.
// Each input has its own small FIFO. An arbiter (round-robin with a per-source
// burst limit, or fixed priority) pops one FIFO head per grant into the output
// register, and tags the word with the index of the input it came from.
module pc_out_arbiter #(
    parameter int N      = 32,
    parameter int Nin    = 3,
    parameter int D      = 4,
    parameter int Nburst = 4,
    localparam int Nsrc  = $clog2(Nin)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [Nin-1:0][N-1:0]   in_d,
    input  logic [Nin-1:0]          in_v,
    output logic [Nin-1:0]          in_a,
    output logic [N-1:0]            out_d,
    output logic [Nsrc-1:0]         out_src,
    output logic                    out_v,
    input  logic                    out_a,
    input  logic                    conf_mode,
    input  logic [Nburst-1:0]       conf_burst,
    output logic [Nin-1:0]          fifo_full
);

    localparam int AW = $clog2(D);
    localparam int CW = AW + 1;

    typedef enum logic {
        S_IDLE,
        S_OWN
    } rr_state_e;

    // Per-input FIFO storage and bookkeeping
    logic [N-1:0]            mem_q [Nin][D];
    logic [Nin-1:0][AW-1:0]  rd_ptr_q;
    logic [Nin-1:0][AW-1:0]  wr_ptr_q;
    logic [Nin-1:0][CW-1:0]  cnt_q;

    logic [Nin-1:0]          full;
    logic [Nin-1:0]          not_empty;
    logic [Nin-1:0]          wr_en;
    logic [Nin-1:0]          rd_en;

    // Arbiter state
    rr_state_e               state_q, state_d;
    logic [Nsrc-1:0]         ptr_q, ptr_d;
    logic [Nburst-1:0]       burst_q, burst_d;
    logic [Nburst-1:0]       burst_lim;
    logic [Nsrc-1:0]         win;
    logic [Nsrc-1:0]         cand;
    logic                    found;
    logic                    any_ne;
    logic                    out_free;
    logic                    grant;

    // Output register
    logic [N-1:0]            out_data_q, out_data_d;
    logic [Nsrc-1:0]         out_src_q, out_src_d;
    logic                    out_v_q, out_v_d;

    // FIFO status, handshake and pop decode
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        full      = '0;
        not_empty = '0;
        in_a      = '0;
        wr_en     = '0;
        rd_en     = '0;
        for (int i = 0; i < Nin; i++) begin
            full[i]      = (cnt_q[i] == CW'(D));
            not_empty[i] = (cnt_q[i] != '0);
            // A full FIFO refuses a word even if it is being popped this cycle.
            in_a[i]      = !full[i] && !reset;
            wr_en[i]     = in_v[i] && in_a[i];
            rd_en[i]     = grant && (win == Nsrc'(i));
        end
    end

    assign fifo_full = full;
    assign any_ne    = |not_empty;
    assign out_free  = !out_v_q || out_a;
    assign grant     = out_free && any_ne;

    // FIFO pointers and occupancy counts
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // pre-edge values regardless of block ordering.
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            for (int i = 0; i < Nin; i++) begin
                if (wr_en[i]) wr_ptr_q[i] <= wr_ptr_q[i] + AW'(1);
                if (rd_en[i]) rd_ptr_q[i] <= rd_ptr_q[i] + AW'(1);
                case ({wr_en[i], rd_en[i]})
                    2'b10:   cnt_q[i] <= cnt_q[i] + CW'(1);
                    2'b01:   cnt_q[i] <= cnt_q[i] - CW'(1);
                    default: cnt_q[i] <= cnt_q[i];
                endcase
            end
        end
    end

    // FIFO data storage
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the counts gate every read, so stale
        // contents are never observed and the array can map onto plain RAM.
        for (int i = 0; i < Nin; i++) begin
            if (wr_en[i]) mem_q[i][wr_ptr_q[i]] <= in_d[i];
        end
    end

    // Arbitration: pick the winner and compute next pointer/burst/state
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        burst_d   = burst_q;
        win       = '0;
        cand      = '0;
        found     = 1'b0;
        burst_lim = (conf_burst == '0) ? Nburst'(1) : conf_burst;

        if (conf_mode) begin
            // Fixed priority: lowest non-empty index; RR bookkeeping parked.
            state_d = S_IDLE;
            burst_d = '0;
            for (int i = 0; i < Nin; i++) begin
                cand = Nsrc'(i);
                if (!found && not_empty[cand]) begin
                    found = 1'b1;
                    win   = cand;
                end
            end
        end else if (state_q == S_OWN && not_empty[ptr_q] && burst_q < burst_lim) begin
            // Current owner keeps the channel until its burst is spent.
            win = ptr_q;
            if (grant) burst_d = burst_q + Nburst'(1);
        end else begin
            // Search from pointer+1 with explicit wrap, so unused codes never appear.
            for (int off = 1; off <= Nin; off++) begin
                if (int'(ptr_q) + off >= Nin) cand = Nsrc'(int'(ptr_q) + off - Nin);
                else                          cand = Nsrc'(int'(ptr_q) + off);
                if (!found && not_empty[cand]) begin
                    found = 1'b1;
                    win   = cand;
                end
            end
            if (grant) begin
                ptr_d   = win;
                burst_d = Nburst'(1);
                state_d = S_OWN;
            end else if (!any_ne) begin
                state_d = S_IDLE;
                burst_d = '0;
            end
        end
    end

    // Arbiter state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= Nsrc'(Nin - 1);
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
        end
    end

    // Output stage next-state: load on grant, drop valid when consumed and idle
    always_comb begin
        out_v_d    = out_v_q;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        if (grant) begin
            out_v_d    = 1'b1;
            out_data_d = mem_q[win][rd_ptr_q[win]];
            out_src_d  = win;
        end else if (out_a) begin
            out_v_d    = 1'b0;
        end
    end

    // Output register
    always_ff @(posedge clk) begin
        if (reset) begin
            out_v_q    <= 1'b0;
            out_data_q <= '0;
            out_src_q  <= '0;
        end else begin
            out_v_q    <= out_v_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
        end
    end

    assign out_v   = out_v_q;
    assign out_d   = out_data_q;
    assign out_src = out_src_q;

endmodule

// File: tb/tb_pc_out_arbiter.sv
// Directed bench for pc_out_arbiter: latency, RR bursts, priority, backpressure, reset.
module tb_pc_out_arbiter;

    localparam int N   = 32;
    localparam int NIN = 3;
    localparam int D   = 4;
    localparam int NB  = 4;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NIN-1:0][N-1:0] in_d = '0;
    logic [NIN-1:0]        in_v = '0;
    logic [NIN-1:0]        in_a;
    logic [N-1:0]          out_d;
    logic [1:0]            out_src;
    logic                  out_v;
    logic                  out_a = 1'b0;
    logic                  conf_mode = 1'b0;
    logic [NB-1:0]         conf_burst = 4'd1;
    logic [NIN-1:0]        fifo_full;

    pc_out_arbiter #(.N(N), .Nin(NIN), .D(D), .Nburst(NB)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_d       (in_d),
        .in_v       (in_v),
        .in_a       (in_a),
        .out_d      (out_d),
        .out_src    (out_src),
        .out_v      (out_v),
        .out_a      (out_a),
        .conf_mode  (conf_mode),
        .conf_burst (conf_burst),
        .fifo_full  (fifo_full)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transfer monitor: records each word that is consumed at the next edge.
    typedef struct {
        logic [1:0]  src;
        logic [31:0] data;
        int          cyc;
    } xfer_t;

    xfer_t mon_q[$];
    int    cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        xfer_t x;
        #2;
        if (!reset && out_v && out_a) begin
            x.src  = out_src;
            x.data = out_d;
            x.cyc  = cyc;
            mon_q.push_back(x);
        end
    end

    // Per-source word counters: word k of source s carries s*256+k.
    int cnt[NIN];

    task automatic step(input logic [NIN-1:0] vmask, input logic oa, input logic [31:0] raw = '0);
        logic [NIN-1:0] acc;
        @(negedge clk);
        out_a = oa;
        in_v  = vmask;
        for (int i = 0; i < NIN; i++)
            in_d[i] = (raw != '0) ? raw : 32'(i * 256 + cnt[i]);
        #1;
        acc = in_v & in_a;
        @(posedge clk);
        for (int i = 0; i < NIN; i++)
            if (acc[i]) cnt[i]++;
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        in_v  = '0;
        out_a = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NIN; i++) cnt[i] = 0;
        mon_q.delete();
    endtask

    task automatic drain(input string tag, input int n);
        for (int s = 0; s < 60 && mon_q.size() < n; s++) step('0, 1'b1);
        check({tag, "_count"}, mon_q.size(), n);
    endtask

    task automatic check_seq(input string tag, input int exp_src[$], input bit nogap);
        int k[NIN];
        for (int i = 0; i < NIN; i++) k[i] = 0;
        for (int i = 0; i < exp_src.size() && i < mon_q.size(); i++) begin
            check($sformatf("%s_src%0d", tag, i), mon_q[i].src, exp_src[i]);
            check($sformatf("%s_data%0d", tag, i), mon_q[i].data, 32'(exp_src[i] * 256 + k[exp_src[i]]));
            k[exp_src[i]]++;
            if (nogap && i > 0)
                check($sformatf("%s_gap%0d", tag, i), mon_q[i].cyc - mon_q[i-1].cyc, 1);
        end
    endtask

    task automatic rr_preload_test(input string tag, input logic [NB-1:0] burst, input int exp_src[$]);
        conf_mode  = 1'b0;
        conf_burst = burst;
        reset_dut();
        for (int s = 0; s < 4; s++) step(3'b111, 1'b0);
        check({tag, "_acc0"}, cnt[0], 4);
        check({tag, "_acc2"}, cnt[2], 4);
        drain(tag, 12);
        check_seq(tag, exp_src, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int e[$];

        // Reset values and single-word latency
        conf_mode  = 1'b0;
        conf_burst = 4'd1;
        reset_dut();
        #1;
        check("rst_out_v", out_v, 0);
        check("rst_out_d", out_d, 0);
        check("rst_out_src", out_src, 0);
        check("rst_fifo_full", fifo_full, 0);
        check("rst_in_a", in_a, 3'b111);
        step(3'b010, 1'b1, 32'hA5);
        check("t1_v_edge1", out_v, 0);
        step('0, 1'b1);
        check("t1_v_edge2", out_v, 1);
        check("t1_d", out_d, 32'hA5);
        check("t1_src", out_src, 1);
        step('0, 1'b1);
        check("t1_v_after", out_v, 0);

        // Round-robin, burst 1, then burst 3, then burst 0 (acts as 1)
        e = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2};
        rr_preload_test("rr_b1", 4'd1, e);
        e = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 1, 2};
        rr_preload_test("rr_b3", 4'd3, e);
        e = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2};
        rr_preload_test("rr_b0", 4'd0, e);

        // Fixed priority: input 0 keeps feeding and starves 1 and 2
        conf_mode  = 1'b1;
        conf_burst = 4'd1;
        reset_dut();
        step(3'b111, 1'b0);
        step(3'b111, 1'b0);
        for (int s = 0; s < 4; s++) step(3'b001, 1'b0);
        check("pri_acc0", cnt[0], 5);
        check("pri_full", fifo_full, 3'b001);
        for (int s = 0; s < 10 && cnt[0] < 8; s++) step(3'b001, 1'b1);
        check("pri_acc0_end", cnt[0], 8);
        drain("pri", 12);
        e = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 2};
        check_seq("pri", e, 1'b0);

        // Backpressure: output stalled 10 cycles while all inputs stream
        conf_mode  = 1'b0;
        conf_burst = 4'd1;
        reset_dut();
        for (int s = 1; s <= 10; s++) begin
            step(3'b111, 1'b0);
            if (s >= 2) begin
                check($sformatf("bp_hold_v%0d", s), out_v, 1);
                check($sformatf("bp_hold_d%0d", s), out_d, 0);
            end
        end
        check("bp_full", fifo_full, 3'b111);
        check("bp_in_a", in_a, 3'b000);
        check("bp_acc0", cnt[0], 5);
        check("bp_acc1", cnt[1], 4);
        check("bp_acc2", cnt[2], 4);
        drain("bp", 13);
        e = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2, 0};
        check_seq("bp", e, 1'b1);

        // Reset mid-operation with part-full FIFOs and a valid output word
        reset_dut();
        step(3'b111, 1'b0);
        step(3'b111, 1'b0);
        check("mr_pre_v", out_v, 1);
        @(negedge clk);
        reset = 1'b1;
        in_v  = '0;
        #1;
        check("mr_in_a", in_a, 3'b000);
        @(posedge clk);
        #1;
        check("mr_out_v", out_v, 0);
        check("mr_full", fifo_full, 3'b000);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NIN; i++) cnt[i] = 0;
        mon_q.delete();
        step(3'b101, 1'b1);
        drain("mr", 2);
        e = '{0, 2};
        check_seq("mr", e, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
